// File: rtl/vadd_pkg.sv
// Shared constants and helpers for the vector-add scheduler.
// Tags are carried at MAX_NREQ width; only the low NREQ bits are ever set.
package vadd_pkg;
  localparam int FP32_W   = 32;
  localparam int VW_DEF   = 512;
  localparam int LANES    = VW_DEF / FP32_W;
  localparam int MAX_NREQ = 8;
  localparam int PTR_W    = 3;

  typedef logic [MAX_NREQ-1:0] tag_t;

  // Round-robin successor of a winning index, wrapping at n requesters.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/vector_add_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// The pointer only advances past the winner when a grant is actually issued.
module rr_arbiter
  import vadd_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int  idx;
    logic hit;
    gnt   = '0;
    ptr_d = ptr_q;
    hit   = 1'b0;
    idx   = 0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!hit && req[idx]) begin
          hit      = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d    = rr_next(PTR_W'(idx), NREQ);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/vector_add_sched.sv
// Time-shares one fixed-latency vector adder between NREQ requesters and routes results back.
// Optional per-requester grant / idle counters when VADD_SCHED_STATS_EN is defined.
module vector_add_sched
  import vadd_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int ADD_LATENCY = 11,
  parameter int VW          = VW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sched_en,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*VW-1:0] req_vec_a,
  input  logic [NREQ*VW-1:0] req_vec_b,
  output logic               add_in_valid,
  output logic [VW-1:0]      add_vec_1,
  output logic [VW-1:0]      add_vec_2,
  input  logic               add_out_valid,
  input  logic [VW-1:0]      add_vec,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [VW-1:0]      rsp_vec,
  output logic               busy,
  output logic               tag_err
`ifdef VADD_SCHED_STATS_EN
  ,
  output logic [NREQ*32-1:0] grant_cnt,
  output logic [31:0]        idle_cnt
`endif
);
  localparam int BW = $clog2(ADD_LATENCY + 1);

  logic [BW-1:0]          blank_q, blank_d;
  logic [NREQ-1:0]        gnt;
  logic                   arb_en, live;
  logic                   add_in_valid_q, add_in_valid_d;
  logic [VW-1:0]          add_vec_1_q, add_vec_1_d, add_vec_2_q, add_vec_2_d;
  tag_t [ADD_LATENCY:0]   tag_q, tag_d;
  tag_t                   tail;
  logic                   tail_v;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [VW-1:0]          rsp_vec_q, rsp_vec_d;
  logic                   tag_err_q, tag_err_d;

  // The adder IP has no reset, so its pipeline may hold garbage for a full latency after rst.
  assign live    = (blank_q == '0);
  assign arb_en  = sched_en & live;
  assign blank_d = live ? blank_q : blank_q - 1'b1;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (req_valid),
    .gnt (gnt)
  );

  always_comb begin
    add_in_valid_d = |gnt;
    add_vec_1_d    = add_vec_1_q;
    add_vec_2_d    = add_vec_2_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        add_vec_1_d = req_vec_a[i*VW +: VW];
        add_vec_2_d = req_vec_b[i*VW +: VW];
      end
    end
  end

  // Tag stage k lines up with the adder output ADD_LATENCY-k cycles before it appears.
  always_comb begin
    tag_d[0] = tag_t'(gnt);
    for (int k = 1; k <= ADD_LATENCY; k++) tag_d[k] = tag_q[k-1];
  end

  assign tail   = tag_q[ADD_LATENCY];
  assign tail_v = |tail;

  always_comb begin
    rsp_valid_d = '0;
    rsp_vec_d   = rsp_vec_q;
    tag_err_d   = tag_err_q;
    if (live) begin
      if (tail_v && add_out_valid) begin
        rsp_valid_d = tail[NREQ-1:0];
        rsp_vec_d   = add_vec;
      end
      if (tail_v != add_out_valid) tag_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q        <= BW'(ADD_LATENCY);
      add_in_valid_q <= 1'b0;
      add_vec_1_q    <= '0;
      add_vec_2_q    <= '0;
      tag_q          <= '0;
      rsp_valid_q    <= '0;
      rsp_vec_q      <= '0;
      tag_err_q      <= 1'b0;
    end else begin
      blank_q        <= blank_d;
      add_in_valid_q <= add_in_valid_d;
      add_vec_1_q    <= add_vec_1_d;
      add_vec_2_q    <= add_vec_2_d;
      tag_q          <= tag_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_vec_q      <= rsp_vec_d;
      tag_err_q      <= tag_err_d;
    end
  end

  assign req_ready    = gnt;
  assign add_in_valid = add_in_valid_q;
  assign add_vec_1    = add_vec_1_q;
  assign add_vec_2    = add_vec_2_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_vec      = rsp_vec_q;
  assign tag_err      = tag_err_q;
  assign busy         = !live | (|tag_q) | add_in_valid_q;

`ifdef VADD_SCHED_STATS_EN
  logic [NREQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]           idle_cnt_q, idle_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i] && grant_cnt_q[i] != '1) grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
    if (sched_en && !(|gnt) && idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign idle_cnt  = idle_cnt_q;
`endif
endmodule

// File: tb/tb_vector_add_sched.sv
// Bench for vector_add_sched: fp32 adder stand-in, round-robin/latency scoreboard,
// fixed-vector table and hand sequences for blanking, drain, tag errors and reset.
module tb_vector_add_sched;
  localparam int NREQ = 4;
  localparam int L    = 11;
  localparam int VW   = 512;
  localparam int LN   = VW / 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sched_en = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*VW-1:0] req_vec_a = '0;
  logic [NREQ*VW-1:0] req_vec_b = '0;
  logic               add_in_valid;
  logic [VW-1:0]      add_vec_1, add_vec_2;
  logic               add_out_valid;
  logic [VW-1:0]      add_vec;
  logic [NREQ-1:0]    rsp_valid;
  logic [VW-1:0]      rsp_vec;
  logic               busy, tag_err;
  logic               inj = 1'b0;
`ifdef VADD_SCHED_STATS_EN
  logic [NREQ*32-1:0] grant_cnt;
  logic [31:0]        idle_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  vector_add_sched #(.NREQ(NREQ), .ADD_LATENCY(L), .VW(VW)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vec_a(req_vec_a), .req_vec_b(req_vec_b),
    .add_in_valid(add_in_valid), .add_vec_1(add_vec_1), .add_vec_2(add_vec_2),
    .add_out_valid(add_out_valid), .add_vec(add_vec),
    .rsp_valid(rsp_valid), .rsp_vec(rsp_vec),
    .busy(busy), .tag_err(tag_err)
`ifdef VADD_SCHED_STATS_EN
    , .grant_cnt(grant_cnt), .idle_cnt(idle_cnt)
`endif
  );

  always #5 clk = ~clk;

  // fp32 <-> real for normal numbers; stimulus uses exactly representable values only.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return '0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [VW-1:0] vsum(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] v;
    for (int l = 0; l < LN; l++) v[l*32 +: 32] = r2f(f2r(a[l*32 +: 32]) + f2r(b[l*32 +: 32]));
    return v;
  endfunction

  function automatic logic [VW-1:0] vrep(input logic [31:0] x);
    return {LN{x}};
  endfunction

  function automatic logic [VW-1:0] vrand();
    logic [VW-1:0] v;
    for (int l = 0; l < LN; l++) v[l*32 +: 32] = r2f(real'($urandom_range(0, 4000)));
    return v;
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Adder stand-in: fixed latency, no reset (like the IP), output valid L cycles after input valid.
  logic [L-1:0]  apv = '0;
  logic [VW-1:0] apd [L];
  always @(posedge clk) begin
    apv <= {apv[L-2:0], add_in_valid};
    for (int k = L-1; k > 0; k--) apd[k] <= apd[k-1];
    apd[0] <= vsum(add_vec_1, add_vec_2);
  end
  assign add_out_valid = apv[L-1] | inj;
  assign add_vec       = apd[L-1];

  // Reference model: round-robin pointer, blanking counter, queue of expected responses.
  typedef struct { int due; logic [NREQ-1:0] own; logic [VW-1:0] v; } exp_t;
  exp_t q[$];
  int cyc = 0;
  int mb = L;
  int mptr = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) mb = L;
    else if (mb > 0) mb--;
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] eg, er;
    logic [VW-1:0]   ev;
    int w;
    if (rst) begin
      q.delete();
      mptr = 0;
    end else begin
      eg = '0;
      w  = -1;
      if (sched_en && mb == 0)
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_valid[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
      if (w >= 0) eg[w] = 1'b1;
      chk("grant", req_ready, eg);
      if (w >= 0) begin
        q.push_back('{cyc + L + 2, eg, vsum(req_vec_a[w*VW +: VW], req_vec_b[w*VW +: VW])});
        mptr = (w + 1) % NREQ;
      end
      er = '0;
      ev = rsp_vec;
      if (q.size() > 0 && q[0].due == cyc) begin
        er = q[0].own;
        ev = q[0].v;
        void'(q.pop_front());
      end
      chk("rsp_valid", rsp_valid, er);
      if (er != '0) chk("rsp_vec", rsp_vec, ev);
    end
  end

  typedef struct { int idx; logic [31:0] a; logic [31:0] b; logic [31:0] y; } tvec_t;
  tvec_t tbl[5];

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b1;
    req_valid = '0;
    inj = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_vec(input tvec_t t);
    int c0, n;
    logic found;
    req_vec_a = '0;
    req_vec_b = '0;
    req_vec_a[t.idx*VW +: VW] = vrep(t.a);
    req_vec_b[t.idx*VW +: VW] = vrep(t.b);
    req_valid = '0;
    req_valid[t.idx] = 1'b1;
    found = 1'b0;
    c0 = 0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[t.idx]) begin found = 1'b1; c0 = cyc; break; end
    end
    chk("tbl_handshake", found, 1'b1);
    nxt();
    req_valid = '0;
    found = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin found = 1'b1; break; end
    end
    chk("tbl_rsp_seen", found, 1'b1);
    chk("tbl_latency", cyc - c0, L + 2);
    chk("tbl_rsp_owner", rsp_valid, 4'b1 << t.idx);
    chk("tbl_rsp_vec", rsp_vec, vrep(t.y));
    nxt();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nr;
    logic [NREQ-1:0] g1;
    tbl[0] = '{0, 32'h3f800000, 32'h40000000, 32'h40400000};  // 1+2=3
    tbl[1] = '{1, 32'h40400000, 32'h40800000, 32'h40e00000};  // 3+4=7
    tbl[2] = '{2, 32'h3f000000, 32'h3e800000, 32'h3f400000};  // .5+.25=.75
    tbl[3] = '{3, 32'h42c80000, 32'h41e00000, 32'h43000000};  // 100+28=128
    tbl[4] = '{2, 32'h00000000, 32'h3f800000, 32'h3f800000};  // 0+1=1

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_add_in_valid", add_in_valid, 1'b0);
    chk("rst_add_vec_1", add_vec_1, '0);
    chk("rst_add_vec_2", add_vec_2, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_vec", rsp_vec, '0);
    chk("rst_tag_err", tag_err, 1'b0);
    chk("rst_busy", busy, 1'b1);

    // Blanking: requests and stray adder pulses are ignored for L cycles
    nxt();
    rst = 1'b0;
    for (int k = 0; k < L; k++) begin
      req_valid = '1;
      sched_en = 1'b1;
      inj = (k == 0 || k == 4 || k == L-1);
      @(negedge clk);
      chk("blank_req_ready", req_ready, '0);
      chk("blank_busy", busy, 1'b1);
      nxt();
    end
    inj = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("blank_end_busy", busy, 1'b0);
    chk("blank_tag_err", tag_err, 1'b0);
    chk("blank_rsp_valid", rsp_valid, '0);
    nxt();

    foreach (tbl[i]) run_vec(tbl[i]);

    // All four requesting from ptr=0: grants rotate 0,1,2,3,...
    do_reset();
    repeat (L) @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_vec_a[i*VW +: VW] = vrand();
      req_vec_b[i*VW +: VW] = vrand();
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant_seq", req_ready, 4'b1 << (k % 4));
      nxt();
    end
    req_valid = '0;
    repeat (L + 4) nxt();

    // sched_en drop after 3 issues: grants stop, in-flight ops drain
    req_valid = '1;
    repeat (3) nxt();
    sched_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_no_grant", req_ready, '0);
      chk("drain_busy", busy, 1'b1);
      nxt();
    end
    req_valid = '0;
    nr = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        nr++;
        if (nr == 3) chk("drain_busy_fall", busy, 1'b0);
      end
    end
    chk("drain_rsp_cnt", nr, 3);
    nxt();

    // Randomised traffic against the scoreboard
    for (int n = 0; n < 300; n++) begin
      req_valid = NREQ'($urandom_range(0, 15));
      sched_en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NREQ; i++) begin
        req_vec_a[i*VW +: VW] = vrand();
        req_vec_b[i*VW +: VW] = vrand();
      end
      nxt();
    end
    req_valid = '0;
    sched_en = 1'b1;
    repeat (L + 5) nxt();

    // Result with no tag: sticky tag_err
    chk("pre_tag_err", tag_err, 1'b0);
    inj = 1'b1;
    nxt();
    inj = 1'b0;
    @(negedge clk);
    chk("tag_err_set", tag_err, 1'b1);
    repeat (5) nxt();
    @(negedge clk);
    chk("tag_err_sticky", tag_err, 1'b1);
    nxt();

    // Reset with five ops in flight
    req_valid = '1;
    repeat (5) nxt();
    req_valid = '0;
    repeat (3) nxt();
    g1 = '0;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", req_ready, '0);
    chk("mid_rst_add_in_valid", add_in_valid, 1'b0);
    chk("mid_rst_add_vec_1", add_vec_1, '0);
    chk("mid_rst_rsp_valid", rsp_valid, '0);
    chk("mid_rst_rsp_vec", rsp_vec, '0);
    chk("mid_rst_tag_err", tag_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < L + 20; n++) begin
      @(negedge clk);
      g1 = g1 | rsp_valid;
    end
    chk("post_rst_no_rsp", g1, '0);
    chk("post_rst_tag_err", tag_err, 1'b0);
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
